pc_fetch_unit: RTL

Instruction fetch stage for the single-cycle RISC-V core: owns the architectural PC register, fetches from instruction memory, and loads the next-PC value computed by the core's next-PC logic. It sources `PCaddress` and `PCincre` for that logic and consumes `PCnext` and `Halt` from it. Instruction memory is accessed over a valid/ready request channel and a valid-only response channel, so the core stalls for variable memory latency.

---
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues instruction fetches, loads the committed next PC.
// Optional FETCH_MISALIGN_TRAP_EN halts with a sticky Misalign flag on unaligned targets.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCnext,
  input  logic        Halt,
  input  logic        Commit,
  output logic [31:0] PCaddress,
  output logic [31:0] PCincre,
  output logic        imReqValid,
  output logic [31:0] imReqAddr,
  input  logic        imReqReady,
  input  logic        imRespValid,
  input  logic [31:0] imRespData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        Halted,
  output logic        Misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        ivalid_q;
  logic        halted_q;
  logic        trap;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  assign trap     = !Halt && (PCnext[1:0] != 2'b00);
  assign Misalign = misalign_q;
`else
  assign trap     = 1'b0;
  assign Misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      req_q      <= 1'b0;
      ivalid_q   <= 1'b0;
      halted_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (imReqReady) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imRespValid) begin
            instr_q  <= imRespData;
            state_q  <= S_EXEC;
            ivalid_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (Commit) begin
            pc_q     <= PCnext;
            ivalid_q <= 1'b0;
            if (Halt || trap) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              req_q   <= 1'b1;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (trap) misalign_q <= 1'b1;
`endif
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q  <= S_IDLE;
          req_q    <= 1'b0;
          ivalid_q <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign PCaddress  = pc_q;
  assign PCincre    = pc_q + 32'd4;
  assign imReqValid = req_q;
  assign imReqAddr  = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = ivalid_q;
  assign Halted     = halted_q;

endmodule
